// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst sequencer in front of a byte-level SPI master: TX/RX FIFOs,
// one master start per byte, inter-byte idle gap, done watchdog and host abort.
module spi_burst_ctrl #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [CW-1:0] tx_count,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [CW-1:0] rx_count,
    input  logic          go,
    input  logic [7:0]    len,
    input  logic          abort,
    output logic          busy,
    output logic [7:0]    bytes_left,
    output logic          burst_done,
    output logic          err,
    output logic          m_start,
    output logic [7:0]    m_wr_data,
    input  logic [7:0]    m_rd_data,
    input  logic          m_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    bytes_left_q, bytes_left_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic [7:0]    m_wr_data_q, m_wr_data_d;

    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    assign tx_ready   = (tx_count_q != FULL_CNT);
    assign rx_valid   = (rx_count_q != '0);
    assign tx_push    = tx_valid && tx_ready;
    assign rx_pop     = rx_ready && rx_valid;
    assign rx_data    = rx_mem[rx_rd_ptr_q];
    assign tx_count   = tx_count_q;
    assign rx_count   = rx_count_q;
    assign busy       = (state_q != S_IDLE);
    assign burst_done = (state_q == S_FIN);
    assign m_start    = (state_q == S_START);
    assign err        = err_q;
    assign bytes_left = bytes_left_q;
    assign m_wr_data  = m_wr_data_q;

    // Storage is written per entry; no reset so it maps onto distributed RAM.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (tx_push && (tx_wr_ptr_q == AW'(gi))) tx_mem[gi] <= tx_data;
            if (rx_push && (rx_wr_ptr_q == AW'(gi))) rx_mem[gi] <= m_rd_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        gap_d        = gap_q;
        wd_d         = wd_q;
        err_d        = 1'b0;
        m_wr_data_d  = m_wr_data_q;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (len != 8'd0) begin
                        state_d      = S_LOAD;
                        bytes_left_d = len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Requiring RX room here reserves the slot the byte will land in.
            S_LOAD: begin
                if ((tx_count_q != '0) && (rx_count_q != FULL_CNT)) begin
                    tx_pop      = 1'b1;
                    m_wr_data_d = tx_mem[tx_rd_ptr_q];
                    state_d     = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    rx_push      = 1'b1;
                    bytes_left_d = bytes_left_q - 8'd1;
                    if (bytes_left_q == 8'd1) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    bytes_left_d = 8'd0;
                    state_d      = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_LOAD;
                else                              gap_d   = gap_q + 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over a same-cycle m_done, watchdog expiry or pending pop.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            bytes_left_d = 8'd0;
            err_d        = 1'b0;
            tx_pop       = 1'b0;
            rx_push      = 1'b0;
            m_wr_data_d  = m_wr_data_q;
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
        tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
        rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bytes_left_q <= '0;
            gap_q        <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            m_wr_data_q  <= '0;
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            tx_count_q   <= '0;
            rx_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            gap_q        <= gap_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            m_wr_data_q  <= m_wr_data_d;
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            tx_count_q   <= tx_count_d;
            rx_count_q   <= rx_count_d;
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: vector table, directed corner sequences
// and randomized bursts scored against FIFO-level queues and a loopback master.
module tb_spi_burst_ctrl;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int TMO   = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [CW-1:0] rx_count;
    logic          go = 1'b0;
    logic [7:0]    len_in = 8'h00;
    logic          abort = 1'b0;
    logic          busy;
    logic [7:0]    bytes_left;
    logic          burst_done;
    logic          err;
    logic          m_start;
    logic [7:0]    m_wr_data;
    logic [7:0]    m_rd_data = 8'h00;
    logic          m_done = 1'b0;

    spi_burst_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_count(tx_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
        .go(go), .len(len_in), .abort(abort), .busy(busy), .bytes_left(bytes_left),
        .burst_done(burst_done), .err(err),
        .m_start(m_start), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Loopback master: answers each m_start after m_lat idle cycles with wr ^ m_mask.
    bit         m_en = 1'b1;
    int         m_lat = 0;
    logic [7:0] m_mask = 8'h00;
    int         inj_cyc = -1;
    bit         m_pend = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_echo = 8'h00;
    logic [7:0] st_data[$];
    int         st_cyc[$];
    int         dn_cyc[$];

    always @(posedge clk) begin
        #2;
        m_done = 1'b0;
        if (!rst_n) m_pend = 1'b0;
        if (cyc == inj_cyc) begin
            m_done    = 1'b1;
            m_rd_data = 8'hEE;
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                m_done    = 1'b1;
                m_rd_data = m_echo;
                m_pend    = 1'b0;
                dn_cyc.push_back(cyc);
            end else begin
                m_cnt--;
            end
        end
        if (m_start) begin
            st_data.push_back(m_wr_data);
            st_cyc.push_back(cyc);
            if (m_en) begin
                m_pend = 1'b1;
                m_cnt  = m_lat;
                m_echo = m_wr_data ^ m_mask;
            end
        end
    end

    int   n_bd = 0, n_err = 0, bd_cyc = 0, err_cyc = 0;
    logic err_busy = 1'b0;
    always @(negedge clk) begin
        if (burst_done) begin n_bd++; bd_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; err_busy = busy; end
    end

    int n_chk = 0, n_pass = 0;
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_bytes_left"}, 32'(bytes_left), 0);
        chk({tag, "_burst_done"}, 32'(burst_done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_m_start"}, 32'(m_start), 0);
        chk({tag, "_m_wr_data"}, 32'(m_wr_data), 0);
        chk({tag, "_tx_count"}, 32'(tx_count), 0);
        chk({tag, "_rx_count"}, 32'(rx_count), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        tx_model.delete();
        rx_model.delete();
        m_en = 1'b1; m_lat = 0; m_mask = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g = 0;
        tx_data = b; tx_valid = 1'b1;
        while (!tx_ready && g < 300) begin step(); g++; end
        chk("push_ready", 32'(tx_ready), 1);
        if (tx_ready) begin
            step();
            tx_model.push_back(b);
        end
        tx_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        chk({tag, "_rx_valid"}, 32'(rx_valid), 1);
        if (rx_valid && rx_model.size() > 0) begin
            e = rx_model.pop_front();
            chk({tag, "_rx_data"}, 32'(rx_data), 32'(e));
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
        end
    endtask

    task automatic start_burst(input logic [7:0] l);
        go = 1'b1; len_in = l;
        step();
        go = 1'b0;
    endtask

    task automatic wait_end(input int budget, input bit conc, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bit acc;
            if (conc) begin
                tx_valid = ($urandom_range(0, 2) == 0);
                tx_data  = 8'($urandom);
            end
            acc = tx_valid && tx_ready;
            step();
            if (acc) tx_model.push_back(tx_data);
            tx_valid = 1'b0;
            if (burst_done || err) begin got = 1'b1; break; end
        end
        tx_valid = 1'b0;
    endtask

    // One normal burst; expected bytes come from the front of the TX queue.
    task automatic run_burst(input int l, input bit conc, input string tag);
        int base = st_data.size();
        int dbase = dn_cyc.size();
        int bd0 = n_bd;
        bit got;
        logic [7:0] exp[$];
        for (int i = 0; i < l && tx_model.size() > 0; i++) exp.push_back(tx_model.pop_front());
        start_burst(8'(l));
        wait_end(l * (GAP + 8 + m_lat) + 50, conc, got);
        chk({tag, "_ended"}, 32'(got), 1);
        step(); step();
        chk({tag, "_n_starts"}, st_data.size() - base, l);
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < st_data.size()) chk({tag, "_wr_byte"}, 32'(st_data[base + i]), 32'(exp[i]));
            rx_model.push_back(exp[i] ^ m_mask);
        end
        for (int i = 0; i + 1 < l; i++)
            if (base + i + 1 < st_cyc.size() && dbase + i < dn_cyc.size())
                chk({tag, "_gap"}, st_cyc[base + i + 1] - dn_cyc[dbase + i], GAP + 2);
        chk({tag, "_burst_done_cnt"}, n_bd - bd0, 1);
        chk({tag, "_tx_count"}, 32'(tx_count), tx_model.size());
        chk({tag, "_rx_count"}, 32'(rx_count), rx_model.size());
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (rx_model.size() > 0 && g < 64) begin pop_check(tag); g++; end
    endtask

    typedef struct {
        int n_push; int len; int lat;
        int exp_starts; int exp_bd; int exp_err; int exp_tx; int exp_rx;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int base, bd0, err0, dbase;
        bit got;
        tbl[0] = '{2, 2, 0, 2, 1, 0, 0, 2};
        tbl[1] = '{3, 1, 3, 1, 1, 0, 2, 1};
        tbl[2] = '{4, 0, 0, 0, 0, 1, 4, 0};
        tbl[3] = '{5, 5, 1, 5, 1, 0, 0, 5};
        tbl[4] = '{8, 3, 2, 3, 1, 0, 5, 3};

        // Reset state
        rst_n = 1'b0;
        step(); step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Vector table: push, go, compare outcome counts and data
        for (int r = 0; r < 5; r++) begin
            logic [7:0] pushed[$];
            do_reset();
            m_lat = tbl[r].lat;
            for (int i = 0; i < tbl[r].n_push; i++) begin
                logic [7:0] b = 8'(r * 37 + i * 11 + 1);
                pushed.push_back(b);
                push_byte(b);
            end
            base = st_data.size(); bd0 = n_bd; err0 = n_err;
            start_burst(8'(tbl[r].len));
            wait_end(600, 1'b0, got);
            step(); step();
            chk("tbl_starts", st_data.size() - base, tbl[r].exp_starts);
            chk("tbl_burst_done", n_bd - bd0, tbl[r].exp_bd);
            chk("tbl_err", n_err - err0, tbl[r].exp_err);
            chk("tbl_tx_count", 32'(tx_count), tbl[r].exp_tx);
            chk("tbl_rx_count", 32'(rx_count), tbl[r].exp_rx);
            for (int i = 0; i < tbl[r].exp_starts && base + i < st_data.size(); i++)
                chk("tbl_wr_byte", 32'(st_data[base + i]), 32'(pushed[i]));
            for (int i = 0; i < tbl[r].exp_rx; i++) rx_model.push_back(pushed[i]);
            drain("tbl");
            $display("vector %0d: push=%0d len=%0d lat=%0d done", r, tbl[r].n_push, tbl[r].len, tbl[r].lat);
        end

        // Two-byte loopback with exact cycle timing
        do_reset();
        push_byte(8'hA5); push_byte(8'h3C);
        base = st_data.size(); dbase = dn_cyc.size(); bd0 = n_bd;
        start_burst(8'd2);
        chk("t1_busy_load", 32'(busy), 1);
        chk("t1_no_start_load", 32'(m_start), 0);
        chk("t1_bytes_left2", 32'(bytes_left), 2);
        step();
        chk("t1_m_start", 32'(m_start), 1);
        chk("t1_wr_a5", 32'(m_wr_data), 8'hA5);
        step();
        chk("t1_start_pulse", 32'(m_start), 0);
        chk("t1_wr_stable", 32'(m_wr_data), 8'hA5);
        for (int i = 0; i < 20 && !rx_valid; i++) step();
        chk("t1_rx_valid", 32'(rx_valid), 1);
        chk("t1_bytes_left1", 32'(bytes_left), 1);
        wait_end(100, 1'b0, got);
        chk("t1_burst_done", 32'(burst_done), 1);
        chk("t1_bytes_left0", 32'(bytes_left), 0);
        step();
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_n_bd", n_bd - bd0, 1);
        if (st_data.size() >= base + 2 && dn_cyc.size() >= dbase + 2) begin
            chk("t1_wr_3c", 32'(st_data[base + 1]), 8'h3C);
            chk("t1_gap", st_cyc[base + 1] - dn_cyc[dbase], GAP + 2);
            chk("t1_bd_timing", bd_cyc - dn_cyc[dbase + 1], 1);
        end else chk("t1_log_size", st_data.size() - base, 2);
        rx_model.push_back(8'hA5); rx_model.push_back(8'h3C);
        drain("t1");
        $display("sequence loopback2: done");

        // TX underrun stall in LOAD
        do_reset();
        push_byte(8'h11);
        base = st_data.size(); bd0 = n_bd;
        start_burst(8'd3);
        repeat (40) step();
        chk("stall_busy", 32'(busy), 1);
        chk("stall_starts", st_data.size() - base, 1);
        chk("stall_bytes_left", 32'(bytes_left), 2);
        push_byte(8'h22); push_byte(8'h33);
        wait_end(200, 1'b0, got);
        step();
        chk("stall_ended", 32'(got), 1);
        chk("stall_rx_count", 32'(rx_count), 3);
        chk("stall_n_bd", n_bd - bd0, 1);
        rx_model.push_back(8'h11); rx_model.push_back(8'h22); rx_model.push_back(8'h33);
        drain("stall");
        $display("sequence underrun_stall: done");

        // RX full blocks the next byte until the host pops
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i));
        run_burst(DEPTH, 1'b0, "fill");
        push_byte(8'h77);
        base = st_data.size();
        start_burst(8'd1);
        repeat (30) step();
        chk("rxfull_no_start", st_data.size() - base, 0);
        chk("rxfull_busy", 32'(busy), 1);
        pop_check("rxfull");
        wait_end(100, 1'b0, got);
        step();
        chk("rxfull_ended", 32'(got), 1);
        chk("rxfull_rx_count", 32'(rx_count), DEPTH);
        if (st_data.size() > base) chk("rxfull_wr", 32'(st_data[base]), 8'h77);
        else chk("rxfull_start_seen", st_data.size() - base, 1);
        void'(tx_model.pop_front());
        rx_model.push_back(8'h77);
        drain("rxfull");
        $display("sequence rx_full: done");

        // Watchdog: master silent
        do_reset();
        m_en = 1'b0;
        push_byte(8'h5A);
        base = st_data.size(); err0 = n_err;
        start_burst(8'd1);
        wait_end(TMO + 50, 1'b0, got);
        chk("wd_err_seen", 32'(got && err), 1);
        chk("wd_busy_same_cycle", 32'(busy), 0);
        step(); step();
        chk("wd_n_err", n_err - err0, 1);
        if (st_cyc.size() > base) chk("wd_latency", err_cyc - (st_cyc[base] + 1), TMO);
        else chk("wd_start_seen", st_data.size() - base, 1);
        chk("wd_err_busy", 32'(err_busy), 0);
        chk("wd_bytes_left", 32'(bytes_left), 0);
        chk("wd_rx_count", 32'(rx_count), 0);
        void'(tx_model.pop_front());
        m_en = 1'b1;
        push_byte(8'h6B);
        run_burst(1, 1'b0, "after_wd");
        drain("after_wd");
        $display("sequence watchdog: done");

        // Abort, stale m_done, then go with len 0
        do_reset();
        m_en = 1'b0;
        push_byte(8'h42);
        start_burst(8'd1);
        for (int i = 0; i < 10 && !m_start; i++) step();
        chk("ab_m_start", 32'(m_start), 1);
        step(); step();
        bd0 = n_bd; err0 = n_err;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_bytes_left", 32'(bytes_left), 0);
        inj_cyc = cyc + 1;
        repeat (6) step();
        chk("ab_rx_count", 32'(rx_count), 0);
        chk("ab_no_err", n_err - err0, 0);
        chk("ab_no_bd", n_bd - bd0, 0);
        chk("ab_busy_after", 32'(busy), 0);
        go = 1'b1; len_in = 8'd0;
        step();
        go = 1'b0;
        chk("len0_err", 32'(err), 1);
        chk("len0_busy", 32'(busy), 0);
        step();
        chk("len0_err_pulse", 32'(err), 0);
        void'(tx_model.pop_front());
        m_en = 1'b1;
        $display("sequence abort: done");

        // Full TX, push rejected, burst with concurrent host pushes
        do_reset();
        m_lat = 2;
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        chk("full_tx_count", 32'(tx_count), DEPTH);
        chk("full_tx_ready", 32'(tx_ready), 0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        step();
        tx_valid = 1'b0;
        chk("full_no_push", 32'(tx_count), DEPTH);
        run_burst(DEPTH, 1'b1, "conc");
        $display("sequence full_concurrent: done");

        // Randomized bursts against the queue model
        for (int it = 0; it < 15; it++) begin
            int l;
            drain("rnd");
            if (tx_model.size() == 0)
                for (int i = 0; i < $urandom_range(1, DEPTH); i++) push_byte(8'($urandom));
            l = $urandom_range(1, tx_model.size());
            m_lat = $urandom_range(0, 3);
            m_mask = 8'($urandom);
            run_burst(l, 1'($urandom_range(0, 1)), "rnd");
            $display("random burst %0d: len=%0d lat=%0d tx_left=%0d", it, l, m_lat, tx_model.size());
        end
        drain("rnd");

        // Reset in the middle of a burst
        while (tx_model.size() < 3) push_byte(8'($urandom));
        m_lat = 3;
        start_burst(8'd3);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tx_model.delete(); rx_model.delete();
        base = st_data.size();
        repeat (20) step();
        chk("midrst_no_start", st_data.size() - base, 0);
        chk("midrst_idle", 32'(busy), 0);
        $display("sequence mid_burst_reset: done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Multi-byte transaction sequencer that sits directly upstream of the byte-level SPI master. It buffers host bytes in a TX FIFO and issues one master `start` per byte, holding `wr_data` stable for the byte. It collects each `rd_data` on `done` into an RX FIFO and inserts a programmable idle gap between bytes so CS deasserts between bytes. A `done` watchdog and a host abort bound every burst.

## Interface
- DEPTH, 16 — entries in each of the TX and RX FIFOs; power of two, ≥2
- GAP_CYCLES, 4 — idle clk cycles between a byte's `m_done` and the next `m_start`; ≥2
- TIMEOUT, 4096 — max clk cycles spent waiting for `m_done` before abort-with-error
- CW — derived, $clog2(DEPTH+1); FIFO count width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- tx_data  in  8  host byte to transmit
- tx_valid  in  1  push tx_data; accepted when tx_valid && tx_ready
- tx_ready  out  1  TX FIFO not full
- tx_count  out  CW  TX FIFO occupancy
- rx_data  out  8  head of RX FIFO (valid when rx_valid)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop; pop occurs when rx_valid && rx_ready
- rx_count  out  CW  RX FIFO occupancy
- go  in  1  start a burst of `len` bytes; sampled only in IDLE
- len  in  8  burst length in bytes, 1..255
- abort  in  1  cancel the current burst
- busy  out  1  state != IDLE
- bytes_left  out  8  bytes remaining in the current burst
- burst_done  out  1  1-cycle pulse; burst completed normally
- err  out  1  1-cycle pulse; go with len==0, or watchdog expiry
- m_start  out  1  1-cycle pulse to the SPI master
- m_wr_data  out  8  byte to the master; stable from m_start until m_done
- m_rd_data  in  8  byte received by the master; valid on m_done
- m_done  in  1  1-cycle pulse from the master; byte finished

## Operation
- States: IDLE, LOAD, START, WAIT, GAP, FIN.
- IDLE: go && len!=0 → LOAD, bytes_left<=len. go && len==0 → err pulse, stay IDLE.
- LOAD: waits until tx_count!=0 and rx_count<DEPTH, which reserves an RX slot. Then pops the TX FIFO into m_wr_data → START. Stalls indefinitely otherwise; an underrun is not an error.
- START: m_start=1 for this single cycle, watchdog cleared → WAIT.
- WAIT: on m_done, writes m_rd_data into the RX FIFO and decrements bytes_left. If bytes_left was 1 → FIN, else → GAP with gap counter cleared. Watchdog reaching TIMEOUT-1 without m_done → err pulse, bytes_left<=0, → IDLE.
- GAP: counts GAP_CYCLES cycles, then → LOAD.
- FIN: burst_done=1 for one cycle → IDLE.
- abort in any non-IDLE state: → IDLE next cycle with bytes_left<=0. No err, no burst_done, no further m_start. A byte already popped is lost. A later m_done is ignored.
- m_done outside WAIT is ignored and writes nothing to RX.
- go outside IDLE is ignored. abort in IDLE has no effect.
- abort takes priority over m_done and over watchdog expiry in the same cycle.
- FIFOs are independent of the state machine:
  - Host push and internal pop in the same cycle keep tx_count unchanged.
  - Host pop and internal push in the same cycle keep rx_count unchanged.
  - Push to a full FIFO is impossible (ready low).
  - Pop from an empty FIFO is a no-op.
  - Pointers wrap modulo DEPTH.
- FIFO contents survive abort and errors. Only rst_n clears them.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, both FIFOs empty, all counters 0.
- Outputs one cycle after reset, each with its value:
  - tx_ready=1.
  - rx_valid=0, busy=0, bytes_left=0.
  - burst_done=0, err=0.
  - m_start=0, m_wr_data=0.
  - tx_count=0, rx_count=0.
- Reset mid-burst behaves identically; no m_start follows.
- go at edge t (TX non-empty, RX has room): LOAD at t+1, m_start high in cycle t+2.
- A tx push accepted at edge t is visible in tx_count at t+1. The same applies to rx_count.
- A byte whose m_done is at edge t: rx_valid visible in cycle t+1. Next m_start comes exactly GAP_CYCLES+2 cycles after m_done (GAP, LOAD, START).
- Last byte with m_done at edge t: burst_done high in cycle t+1, busy low in cycle t+2.
- Watchdog error: err in the cycle after expiry, busy low the same cycle.

## Test plan
- Push 0xA5,0x3C; go, len=2; loopback master echoes → two m_start pulses with m_wr_data 0xA5 then 0x3C, separated by GAP_CYCLES+2 cycles after m_done. RX holds 0xA5,0x3C. One burst_done. bytes_left 2→1→0.
- go, len=3 with one byte queued → controller stalls in LOAD after byte 1. Pushing 2 more bytes later resumes the burst → burst_done, rx_count=3.
- RX pre-filled to DEPTH, go, len=1 → no m_start until host pops one entry. Then the byte completes and rx_count returns to DEPTH.
- Master never returns m_done → err pulse exactly TIMEOUT cycles after WAIT entry, busy=0. The next go works normally.
- abort two cycles after m_start, then a stale m_done → no RX write, no err/burst_done, busy=0 next cycle. go with len=0 → err pulse, busy stays 0.
- Push DEPTH bytes (tx_ready drops at DEPTH) while a burst pops simultaneously → tx_count consistent with no lost or duplicated byte. Assert rst_n=0 mid-burst → all outputs return to reset values.
